// File: rtl/vid_stream_if.sv
// -----------------------------------------------------------------------------
// vid_stream_if
//   Output bundle of the video stream source.
//   Stream side (consumed by overlay stages):
//     out_vsync  one-clock frame-start pulse
//     out_req    high for each active pixel
//     out_eol    last active pixel of a line
//     out_eof    last active pixel of the frame
//     out_pixel  {R,G,B}, zero outside the active region
//   Raw side (consumed by the output encoder):
//     vid_hsync, vid_vsync  active-high syncs
//     vid_de                data enable, identical to out_req
//   master: the generator drives everything; slave: consumers observe.
// -----------------------------------------------------------------------------
interface vid_stream_if;
    logic        out_vsync;
    logic        out_req;
    logic        out_eol;
    logic        out_eof;
    logic [23:0] out_pixel;
    logic        vid_hsync;
    logic        vid_vsync;
    logic        vid_de;

    modport master (
        output out_vsync, out_req, out_eol, out_eof, out_pixel,
        output vid_hsync, vid_vsync, vid_de
    );

    modport slave (
        input out_vsync, out_req, out_eol, out_eof, out_pixel,
        input vid_hsync, vid_vsync, vid_de
    );
endinterface

// File: rtl/vid_stream_gen.sv
// -----------------------------------------------------------------------------
// vid_stream_gen
//   Raster timing generator and test-pattern source at the head of the
//   video-out pipeline.
//   Ports:
//     vo_clk       pixel clock, the only clock
//     vo_reset_    asynchronous active-low reset
//     pattern_sel  0 solid, 1 colour bars, 2 gradient, 3 checkerboard;
//                  latched once per frame at the vsync-start cycle
//     vout         vid_stream_if master: stream + raw sync outputs
//   All outputs are registered one clock after the counter state they
//   describe, so stream and raw signals stay mutually aligned.
//   The counters reset to the vsync-start position, so the first thing seen
//   after reset is a vsync pulse rather than a partial frame.
// -----------------------------------------------------------------------------
module vid_stream_gen #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter logic [23:0] SOLID_COLOR = 24'h000080
) (
    input  logic         vo_clk,
    input  logic         vo_reset_,
    input  logic [1:0]   pattern_sel,
    vid_stream_if.master vout
);

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    // Region bounds compared at 32 bits so an end bound equal to the
    // counter's wrap value cannot truncate.
    localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
    localparam logic [31:0] H_EOL     = 32'(H_ACTIVE - 1);
    localparam logic [31:0] HS_BEG    = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
    localparam logic [31:0] V_EOF     = 32'(V_ACTIVE - 1);
    localparam logic [31:0] VS_BEG    = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

    // Raster position and pattern state
    logic [HW-1:0] h_cnt_q,   h_cnt_d;
    logic [VW-1:0] v_cnt_q,   v_cnt_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    pattern_e      pat_q,     pat_d;

    // Registered outputs
    logic          out_vsync_q, out_vsync_d;
    logic          out_req_q,   out_req_d;
    logic          out_eol_q,   out_eol_d;
    logic          out_eof_q,   out_eof_d;
    logic [23:0]   out_pixel_q, out_pixel_d;
    logic          vid_hsync_q, vid_hsync_d;
    logic          vid_vsync_q, vid_vsync_d;

    logic [31:0]   h_ext;
    logic [31:0]   v_ext;
    logic          line_wrap;
    logic          frame_start;
    logic          active;
    logic [7:0]    grad_b;

    // -------------------------------------------------------------------------
    // Counters, bar sub-counter and per-frame pattern register
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; that is what keeps these blocks latch-free.
        h_cnt_d   = h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        pat_d     = pat_q;

        line_wrap   = (h_cnt_q == H_LAST);
        frame_start = (h_cnt_q == '0) && (v_cnt_q == V_VS_BEG);

        if (line_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end

        // The bar sub-counter tracks the bar containing h_cnt_q; it restarts
        // with the line so no divider is needed for the bar index.
        if (line_wrap) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (32'(h_cnt_q) < H_ACT_END) begin
            if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 1'b1;
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
            end
        end

        if (frame_start) begin
            pat_d = pattern_e'(pattern_sel);
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the current counter state
    // -------------------------------------------------------------------------
    always_comb begin
        h_ext  = 32'(h_cnt_q);
        v_ext  = 32'(v_cnt_q);
        active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        grad_b = h_ext[7:0] + v_ext[7:0];

        out_vsync_d = (h_cnt_q == '0) && (v_cnt_q == V_VS_BEG);
        out_req_d   = active;
        out_eol_d   = active && (h_ext == H_EOL);
        out_eof_d   = active && (h_ext == H_EOL) && (v_ext == V_EOF);
        vid_hsync_d = (h_ext >= HS_BEG) && (h_ext < HS_END);
        vid_vsync_d = (v_ext >= VS_BEG) && (v_ext < VS_END);
        out_pixel_d = 24'h000000;

        if (active) begin
            case (pat_q)
                PAT_SOLID: out_pixel_d = SOLID_COLOR;
                PAT_BARS: begin
                    case (bar_idx_q)
                        3'd0:    out_pixel_d = 24'hFFFFFF;
                        3'd1:    out_pixel_d = 24'hFFFF00;
                        3'd2:    out_pixel_d = 24'h00FFFF;
                        3'd3:    out_pixel_d = 24'h00FF00;
                        3'd4:    out_pixel_d = 24'hFF00FF;
                        3'd5:    out_pixel_d = 24'hFF0000;
                        3'd6:    out_pixel_d = 24'h0000FF;
                        default: out_pixel_d = 24'h000000;
                    endcase
                end
                PAT_GRAD:  out_pixel_d = {h_ext[7:0], v_ext[7:0], grad_b};
                PAT_CHECK: out_pixel_d = (h_ext[4] ^ v_ext[4]) ? 24'hFFFFFF : 24'h000000;
                default:   out_pixel_d = 24'h000000;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge vo_clk or negedge vo_reset_) begin
        if (!vo_reset_) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= V_VS_BEG;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            pat_q       <= PAT_SOLID;
            out_vsync_q <= 1'b0;
            out_req_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_pixel_q <= 24'h000000;
            vid_hsync_q <= 1'b0;
            vid_vsync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of its inputs regardless of statement order.
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            pat_q       <= pat_d;
            out_vsync_q <= out_vsync_d;
            out_req_q   <= out_req_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            out_pixel_q <= out_pixel_d;
            vid_hsync_q <= vid_hsync_d;
            vid_vsync_q <= vid_vsync_d;
        end
    end

    assign vout.out_vsync = out_vsync_q;
    assign vout.out_req   = out_req_q;
    assign vout.out_eol   = out_eol_q;
    assign vout.out_eof   = out_eof_q;
    assign vout.out_pixel = out_pixel_q;
    assign vout.vid_hsync = vid_hsync_q;
    assign vout.vid_vsync = vid_vsync_q;
    assign vout.vid_de    = out_req_q;

endmodule

// File: doc/vid_stream_gen.md
# vid_stream_gen

Video stream source at the head of the video-out pipeline. Generates raster timing from parameterised horizontal/vertical counters and emits the vsync/req/eol/eof/pixel stream consumed by downstream overlay stages (e.g. the character generator), plus raw hsync/vsync/de for the output encoder. Pixel content is a selectable test pattern, giving a self-contained picture at bringup.

## Interface
- H_ACTIVE, 640, active pixels per line; must be a multiple of 8
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- SOLID_COLOR, 24'h000080, pixel value for pattern 0
- vo_clk  in  1  pixel clock; the block's only clock
- vo_reset_  in  1  reset, asynchronous, active-low
- pattern_sel  in  2  0 solid, 1 colour bars, 2 gradient, 3 checkerboard
- out_vsync  out  1  one-clock frame-start pulse
- out_req  out  1  high for each active pixel
- out_eol  out  1  high with last active pixel of each line
- out_eof  out  1  high with last active pixel of the frame
- out_pixel  out  24  [23:16] R, [15:8] G, [7:0] B; 0 when out_req low
- vid_hsync  out  1  raw hsync, active high
- vid_vsync  out  1  raw vsync, active high
- vid_de  out  1  data enable; identical to out_req

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt runs 0..H_TOTAL-1 and wraps to 0, incrementing v_cnt; v_cnt wraps 0 after V_TOTAL-1.
- Line/frame order: active, front porch, sync, back porch. Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync region: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync region: same form on v_cnt, line-granular (changes on h_cnt==0).
- out_vsync pulses once per frame at h_cnt==0, v_cnt==V_ACTIVE+V_FP (vsync start), strictly between the previous frame's eof and the next frame's first req.
- out_eol: active and h_cnt==H_ACTIVE-1. out_eof: out_eol and v_cnt==V_ACTIVE-1; eof never occurs without eol.
- pattern_sel sampled into a frame register on the out_vsync cycle; mid-frame changes take effect at the next frame.
- Patterns (x=h_cnt, y=v_cnt in active region):
  - 0: SOLID_COLOR.
  - 1: 8 bars of H_ACTIVE/8 pixels, left to right FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Bar index from a sub-counter cleared at h_cnt==0, not a divider.
  - 2: R=x[7:0], G=y[7:0], B=(x+y) mod 256.
  - 3: FFFFFF when x[4]^y[4], else 000000 (16x16 cells).
- Reset: h_cnt=0, v_cnt=V_ACTIVE+V_FP, frame pattern register=0, so the first post-reset event is a vsync pulse, never a partial frame.

## Timing
- All outputs registered; one clock from counter state to outputs. All stream and raw signals derive from the same counter state and remain mutually aligned.
- Reset values: every output 0.
- First clock after reset deassertion: counters at vsync start, so out_vsync=1 and vid_vsync=1 on the first output cycle.
- Asserting reset mid-frame clears all outputs asynchronously; the stream restarts cleanly with vsync; no req/eol/eof is emitted for the truncated frame.
- No backpressure: out_req is a fixed schedule; downstream must accept every pixel.
- Line period exactly H_TOTAL clocks; frame period exactly H_TOTAL*V_TOTAL clocks (420000 with defaults).

## Test plan
- Reset release, defaults -> first output cycle out_vsync=1, vid_vsync=1 for 2 lines (1600 clocks); first out_req occurs 34*800 + 800 - 0 clocks later, at v_cnt=0,h_cnt=0.
- Run one full frame -> exactly 307200 req cycles, 480 eol, 1 eof coincident with last eol, 1 vsync; vsync-to-vsync distance 420000 clocks.
- pattern_sel=1 -> pixels 0..79 = FFFFFF, 80..159 = FFFF00, ..., 560..639 = 000000 on every line.
- pattern_sel=2 -> at (x=300,y=10) pixel = 2C0A36; pattern_sel=3 -> (16,0)=FFFFFF, (16,16)=000000.
- Change pattern_sel from 0 to 3 mid-frame -> remaining pixels stay SOLID_COLOR; checkerboard starts at the next frame's first req.
- Assert vo_reset_ at line 200 mid-line -> all outputs 0 immediately; after release, vsync precedes any req; frame counts as in scenario 2.
